// File: rtl/even_clk_div_ctrl.sv
// even_clk_div_ctrl: run/stop and ratio-change controller for a toggle-based
// even clock divider. Output period = 2*cur_half clk cycles, 50% duty.
// New ratios and stops take effect only at the end of a high phase, so
// div_out never shows a runt or stretched pulse.
//
// Ports:
//   clk, resetn            system clock, asynchronous active-low reset
//   en                     level run request (0 = stop at next boundary)
//   cfg_valid/cfg_ready    config handshake; cfg_half sampled on acceptance
//   cfg_half               requested half-period in clk cycles (0 is rejected)
//   cfg_done               one-cycle pulse: accepted config now in effect
//   cfg_err                one-cycle pulse: accepted config was zero, discarded
//   div_out                divided output
//   active                 divider running (RUN/PEND/STOPPING)
//   cur_half               half-period currently in effect
module even_clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic             div_out,
  output logic             active,
  output logic [CNT_W-1:0] cur_half
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cur_half_nxt;
  logic [CNT_W-1:0] pend_half, pend_half_nxt;
  logic             div_nxt, done_nxt, err_nxt;
  logic             accept, cfg_zero, phase_end, boundary;

  // Config is only taken while no change or stop is already in flight.
  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign active    = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_zero  = (cfg_half == '0);

  // Last cycle of a phase; the falling-edge one is the only safe place
  // to change the ratio or stop without distorting a pulse.
  assign phase_end = (state != IDLE) && (cnt == (cur_half - ONE));
  assign boundary  = phase_end && div_out;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    div_nxt       = div_out;
    cur_half_nxt  = cur_half;
    pend_half_nxt = pend_half;
    done_nxt      = 1'b0;
    err_nxt       = accept && cfg_zero;

    if (state != IDLE) begin
      if (phase_end) begin
        div_nxt = ~div_out;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end

    // At a boundary the toggle above already yields div_out=0 and cnt=0,
    // so leaving to IDLE there needs no extra clearing.
    case (state)
      IDLE: begin
        if (accept && !cfg_zero) begin
          cur_half_nxt = cfg_half;
          done_nxt     = 1'b1;
        end
        if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept && !cfg_zero) begin
          pend_half_nxt = cfg_half;
          state_nxt     = PEND;
        end else if (!en) begin
          state_nxt = boundary ? IDLE : STOPPING;
        end
      end
      PEND: begin
        if (boundary) begin
          cur_half_nxt = pend_half;
          done_nxt     = 1'b1;
          state_nxt    = en ? RUN : IDLE;
        end
      end
      STOPPING: begin
        if (boundary) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      div_out   <= 1'b0;
      cur_half  <= ONE;
      pend_half <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      div_out   <= div_nxt;
      cur_half  <= cur_half_nxt;
      pend_half <= pend_half_nxt;
      cfg_done  <= done_nxt;
      cfg_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_even_clk_div_ctrl.sv
// Bench for even_clk_div_ctrl: directed stimulus, a phase-countdown model
// of the divider checked every cycle, plus literal expectations per scenario.
module tb_even_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk       = 1'b0;
  logic             resetn    = 1'b0;
  logic             en        = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half  = '0;
  logic             cfg_ready, cfg_done, cfg_err, div_out, active;
  logic [CNT_W-1:0] cur_half;

  int checks   = 0;
  int failures = 0;

  even_clk_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .active    (active),
    .cur_half  (cur_half)
  );

  always #5 clk = ~clk;

  // Model: a running divider holds its level for m_half edges, counted down
  // in m_rem. Pending ratio / stop requests resolve when a high phase ends.
  bit m_run    = 1'b0;
  bit m_stop   = 1'b0;
  bit m_pend_v = 1'b0;
  bit m_lvl    = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  int m_half   = 1;
  int m_pend   = 0;
  int m_rem    = 0;
  bit acc, acc_nz, fall, old_pend, old_stop;

  function automatic bit exp_ready();
    return !(m_pend_v || m_stop);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_run = 0; m_stop = 0; m_pend_v = 0; m_lvl = 0;
      m_done = 0; m_err = 0; m_half = 1; m_pend = 0; m_rem = 0;
    end else begin
      acc    = cfg_valid && exp_ready();
      m_done = 0;
      m_err  = acc && (cfg_half == 0);
      acc_nz = acc && (cfg_half != 0);
      if (!m_run) begin
        if (acc_nz) begin
          m_half = int'(cfg_half);
          m_done = 1;
        end
        if (en) begin
          m_run = 1;
          m_lvl = 0;
          m_rem = m_half;
        end
      end else begin
        old_pend = m_pend_v;
        old_stop = m_stop;
        fall     = (m_rem == 1) && m_lvl;
        if (m_rem == 1) begin
          m_lvl = !m_lvl;
          m_rem = m_half;
        end else begin
          m_rem = m_rem - 1;
        end
        if (fall) begin
          if (old_pend) begin
            m_half   = m_pend;
            m_pend_v = 0;
            m_done   = 1;
            m_rem    = m_half;
            if (!en) m_run = 0;
          end else if (old_stop) begin
            m_run  = 0;
            m_stop = 0;
          end else if (!en && !acc_nz) begin
            m_run = 0;
          end
        end else if (!old_pend && !old_stop && !en && !acc_nz) begin
          m_stop = 1;
        end
        if (acc_nz) begin
          m_pend_v = 1;
          m_pend   = int'(cfg_half);
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    cmp("m_div_out",   32'(div_out),   32'(m_lvl));
    cmp("m_active",    32'(active),    32'(m_run));
    cmp("m_cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
    cmp("m_cfg_done",  32'(cfg_done),  32'(m_done));
    cmp("m_cfg_err",   32'(cfg_err),   32'(m_err));
    cmp("m_cur_half",  32'(cur_half),  32'(m_half));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_div(input logic v, input int budget, input string nm);
    int n = 0;
    while (div_out !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (div_out !== v) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: div_out=%0b required %0b", nm, div_out, v);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (active !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (active !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: active=%0b required 0", nm, active);
    end
  endtask

  initial begin
    // 1: reset values, then div2 run
    @(negedge clk);
    cmp("rst_div",   32'(div_out),   32'd0);
    cmp("rst_act",   32'(active),    32'd0);
    cmp("rst_ready", 32'(cfg_ready), 32'd1);
    cmp("rst_half",  32'(cur_half),  32'd1);
    cmp("rst_done",  32'(cfg_done),  32'd0);
    cmp("rst_err",   32'(cfg_err),   32'd0);
    resetn = 1'b1;
    en     = 1'b1;
    step(1);
    cmp("t1_act", 32'(active),  32'd1);
    cmp("t1_d0",  32'(div_out), 32'd0);
    step(1); cmp("t1_d1", 32'(div_out), 32'd1);
    step(1); cmp("t1_d2", 32'(div_out), 32'd0);
    step(1); cmp("t1_d3", 32'(div_out), 32'd1);
    step(1); cmp("t1_d4", 32'(div_out), 32'd0);
    en = 1'b0;
    wait_idle(10, "t1_stop");
    cmp("t1_idle_div", 32'(div_out), 32'd0);

    // 2: config 3 in IDLE, then run 3 high / 3 low
    cfg_valid = 1'b1;
    cfg_half  = 8'd3;
    step(1);
    cfg_valid = 1'b0;
    cmp("t2_done",  32'(cfg_done), 32'd1);
    cmp("t2_half",  32'(cur_half), 32'd3);
    step(1);
    cmp("t2_done0", 32'(cfg_done), 32'd0);
    en = 1'b1;
    step(1); cmp("t2_act",  32'(active),  32'd1);
    step(2); cmp("t2_pre",  32'(div_out), 32'd0);
    step(1); cmp("t2_rise", 32'(div_out), 32'd1);
    step(2); cmp("t2_hi3",  32'(div_out), 32'd1);
    step(1); cmp("t2_fall", 32'(div_out), 32'd0);
    step(2); cmp("t2_lo3",  32'(div_out), 32'd0);
    step(1); cmp("t2_rise2",32'(div_out), 32'd1);

    // 3: ratio 2 -> 3 change requested in the first high cycle
    en = 1'b0;
    wait_idle(20, "t3_stop");
    cfg_valid = 1'b1;
    cfg_half  = 8'd2;
    step(1);
    cfg_valid = 1'b0;
    cmp("t3_half2", 32'(cur_half), 32'd2);
    en = 1'b1;
    wait_div(1'b1, 10, "t3_rise");
    cmp("t3_rdy_run", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_half  = 8'd3;
    step(1);
    cfg_valid = 1'b0;
    cmp("t3_rdy_pend", 32'(cfg_ready), 32'd0);
    cmp("t3_hi2",      32'(div_out),   32'd1);
    cmp("t3_old_half", 32'(cur_half),  32'd2);
    step(1);
    cmp("t3_fall", 32'(div_out),   32'd0);
    cmp("t3_done", 32'(cfg_done),  32'd1);
    cmp("t3_half", 32'(cur_half),  32'd3);
    cmp("t3_rdy",  32'(cfg_ready), 32'd1);
    step(2); cmp("t3_lo3",  32'(div_out), 32'd0);
    step(1); cmp("t3_rise", 32'(div_out), 32'd1);

    // 4: zero config rejected in RUN
    cfg_valid = 1'b1;
    cfg_half  = 8'd0;
    step(1);
    cfg_valid = 1'b0;
    cmp("t4_err",  32'(cfg_err),   32'd1);
    cmp("t4_half", 32'(cur_half),  32'd3);
    cmp("t4_rdy",  32'(cfg_ready), 32'd1);
    cmp("t4_done", 32'(cfg_done),  32'd0);
    step(1);
    cmp("t4_err0", 32'(cfg_err),   32'd0);
    cmp("t4_hi",   32'(div_out),   32'd1);

    // 5: stop requested in the first high cycle of a 3-cycle phase
    wait_div(1'b0, 10, "t5_low");
    wait_div(1'b1, 10, "t5_rise");
    en = 1'b0;
    step(2);
    cmp("t5_hi3",  32'(div_out), 32'd1);
    cmp("t5_act1", 32'(active),  32'd1);
    step(1);
    cmp("t5_div0", 32'(div_out), 32'd0);
    cmp("t5_act0", 32'(active),  32'd0);
    step(3);
    cmp("t5_held", 32'(div_out), 32'd0);

    // 6: asynchronous reset while a change to 5 is pending
    en = 1'b1;
    wait_div(1'b1, 10, "t6_rise");
    cfg_valid = 1'b1;
    cfg_half  = 8'd5;
    step(1);
    cfg_valid = 1'b0;
    cmp("t6_pend_rdy", 32'(cfg_ready), 32'd0);
    cmp("t6_pend_div", 32'(div_out),   32'd1);
    #2 resetn = 1'b0;
    #1;
    cmp("t6_rst_div",  32'(div_out),   32'd0);
    cmp("t6_rst_act",  32'(active),    32'd0);
    cmp("t6_rst_done", 32'(cfg_done),  32'd0);
    cmp("t6_rst_half", 32'(cur_half),  32'd1);
    cmp("t6_rst_rdy",  32'(cfg_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    step(1);
    cmp("t6_act",  32'(active),   32'd1);
    cmp("t6_d0",   32'(div_out),  32'd0);
    step(1); cmp("t6_d1", 32'(div_out), 32'd1);
    step(1); cmp("t6_d2", 32'(div_out), 32'd0);
    step(1); cmp("t6_d3", 32'(div_out), 32'd1);
    step(4);
    cmp("t6_half", 32'(cur_half), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
